// File: rtl/btn_pkg.sv
// Shared constants and types for the PicoBlaze push-button conditioner.
package btn_pkg;

  localparam int unsigned BTN_C = 4;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_R = 0;

  localparam logic [7:0] PORT_BUTTONS = 8'h0f;

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rp_state_t;

  // Width of a counter that must hold 0..limit-1 (never narrower than one bit).
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: two-flop synchroniser, tick-based debounce, press edge and auto-repeat FSM.
module btn_debounce_cell
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS     = 10,
  parameter int unsigned REPEAT_DELAY_TICKS = 500,
  parameter int unsigned REPEAT_RATE_TICKS  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_repeat
);

  localparam int unsigned DW     = cnt_w(DEBOUNCE_TICKS);
  localparam int unsigned RP_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                                   REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int unsigned RW     = cnt_w(RP_MAX);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE_TICKS - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt;
  logic          level_prev;

  rp_state_t     state_q, state_d;
  logic [RW-1:0] rp_cnt_q, rp_cnt_d;
  logic          repeat_d;

  // Synchroniser, debounce counter and registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      db_cnt     <= '0;
      btn_level  <= 1'b0;
      level_prev <= 1'b0;
      btn_press  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_raw};
      level_prev <= btn_level;
      btn_press  <= btn_level & ~level_prev;
      if (sync_q[1] == btn_level) begin
        db_cnt <= '0;
      end else if (tick) begin
        if (db_cnt == DB_LAST) begin
          btn_level <= sync_q[1];
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RP_IDLE;
      rp_cnt_q   <= '0;
      btn_repeat <= 1'b0;
    end else begin
      state_q    <= state_d;
      rp_cnt_q   <= rp_cnt_d;
      btn_repeat <= repeat_d;
    end
  end

  // Repeat FSM next state; a released button always returns to idle.
  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    repeat_d = 1'b0;
    if (!btn_level) begin
      state_d  = RP_IDLE;
      rp_cnt_d = '0;
    end else begin
      case (state_q)
        RP_IDLE: begin
          if (btn_press) begin
            state_d  = RP_DELAY;
            rp_cnt_d = '0;
          end
        end
        RP_DELAY: begin
          if (tick) begin
            if (rp_cnt_q == RD_LAST) begin
              repeat_d = 1'b1;
              state_d  = RP_REPEAT;
              rp_cnt_d = '0;
            end else begin
              rp_cnt_d = rp_cnt_q + RW'(1);
            end
          end
        end
        RP_REPEAT: begin
          if (tick) begin
            if (rp_cnt_q == RR_LAST) begin
              repeat_d = 1'b1;
              rp_cnt_d = '0;
            end else begin
              rp_cnt_d = rp_cnt_q + RW'(1);
            end
          end
        end
        default: begin
          state_d  = RP_IDLE;
          rp_cnt_d = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for PicoBlaze port 0x0f: shared debounce tick, per-button cells,
// sticky event register cleared by the software read strobe.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN            = 5,
  parameter int unsigned TICK_CYCLES        = 40000,
  parameter int unsigned DEBOUNCE_TICKS     = 10,
  parameter int unsigned REPEAT_DELAY_TICKS = 500,
  parameter int unsigned REPEAT_RATE_TICKS  = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               rd_clr,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_event,
  output logic               irq_req
);

  localparam int unsigned PW = cnt_w(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]      presc_q;
  logic               tick;
  logic [NUM_BTN-1:0] btn_repeat;

  assign tick = (presc_q == PRESC_LAST);

  // Free-running debounce prescaler shared by all cells.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

  // Set beats clear so an event arriving during the read is kept for the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_event <= '0;
    end else begin
      btn_event <= (btn_event & ~{NUM_BTN{rd_clr}}) | btn_press | btn_repeat;
    end
  end

  assign irq_req = |btn_event;

endmodule
